// File: rtl/exec_ctrl.sv
// Execution controller: gates the core with a per-microcycle clock enable.
// It provides halt, step, run and run-to-breakpoint control from a debounced pushbutton.
module exec_ctrl #(
  parameter int DEBOUNCE_LEN = 50000,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             button,
  input  logic [1:0]       mode,
  input  logic [7:0]       bp_addr,
  input  logic [7:0]       pc,
  input  logic             fetch,
  output logic             core_en,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] insn_count
);

  localparam int DCNT_W = $clog2(DEBOUNCE_LEN);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_LEN - 1);

  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_RUN  = 2'b10;
  localparam logic [1:0] MODE_BP   = 2'b11;

  logic              s1_q, s1_d, s2_q, s2_d;
  logic              db_q, db_d, db_prev_q, db_prev_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [1:0]        state_q, state_d;
  logic              moved_q, moved_d;
  logic              bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic btn_pulse;
  logic fetch_done;
  logic stop_bp;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    s1_d      = button;
    s2_d      = s1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    dcnt_d    = '0;
    // The level flips only after DEBOUNCE_LEN consecutive disagreeing cycles.
    if (s2_q != db_q) begin
      if (dcnt_q == DCNT_MAX) db_d = s2_q;
      else                    dcnt_d = dcnt_q + DCNT_W'(1);
    end
  end

  assign btn_pulse  = db_q & ~db_prev_q;
  assign fetch_done = fetch & moved_q;
  assign stop_bp    = fetch_done & (pc == bp_addr) & (mode == MODE_BP);

  always_comb begin
    state_d  = state_q;
    bp_hit_d = bp_hit_q;
    moved_d  = moved_q;
    core_en  = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        if (btn_pulse) begin
          unique case (mode)
            MODE_STEP: state_d = ST_STEP;
            MODE_RUN, MODE_BP: begin
              state_d  = ST_RUN;
              bp_hit_d = 1'b0;
            end
            MODE_HALT: state_d = ST_HALT;
          endcase
        end
      end
      ST_STEP: begin
        // Stop before the next instruction is latched.
        core_en = ~fetch_done;
        if (fetch_done) state_d = ST_HALT;
      end
      ST_RUN: begin
        core_en = ~stop_bp;
        if (stop_bp) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else if (btn_pulse) begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
    if (res) core_en = 1'b0;
    if (core_en) moved_d = 1'b1;
    // A fresh start clears moved so a resume at the breakpoint address proceeds.
    if (state_q == ST_HALT && state_d != ST_HALT) moved_d = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (core_en & fetch) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (res) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      dcnt_q    <= '0;
      state_q   <= ST_HALT;
      moved_q   <= 1'b0;
      bp_hit_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      dcnt_q    <= dcnt_d;
      state_q   <= state_d;
      moved_q   <= moved_d;
      bp_hit_q  <= bp_hit_d;
      cnt_q     <= cnt_d;
    end
  end

  assign halted     = (state_q == ST_HALT);
  assign bp_hit     = bp_hit_q;
  assign insn_count = cnt_q;

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Execution controller that sequences the microcoded accumulator core. It replaces the free-running core clock with a per-microcycle clock enable and adds halt, single-instruction step, run and run-to-breakpoint control from the board pushbutton and a mode selector. It sits in `pc_system` between the board inputs and the `processor`/`memory_decoder` enable path. It watches `pc_out` and an instruction-boundary strobe from the core, and reports status back to the board for the LEDs and the 7-segment debug display.

## Interface
- `DEBOUNCE_LEN`, default 50000 — consecutive `clk` cycles the synchronized button must differ from the debounced level before the debounced level flips; legal range is ≥2.
- `CNT_W`, default 16 — width of the retired-instruction counter.

- `clk`  in  1 — board clock; the only clock in the block.
- `res`  in  1 — reset, synchronous, active-high.
- `button`  in  1 — raw asynchronous pushbutton, high when pressed.
- `mode`  in  2 — execution mode: `00` halt, `01` step, `10` run, `11` run-to-breakpoint.
- `bp_addr`  in  8 — breakpoint program address.
- `pc`  in  8 — core `pc_out`.
- `fetch`  in  1 — core strobe, high during the microcycle in which the core latches the instruction at `pc`.
- `core_en`  out  1 — clock enable to the core and to the memory write path; the core advances one microcycle per cycle in which this is high.
- `halted`  out  1 — high when the FSM is in HALT.
- `bp_hit`  out  1 — sticky flag: execution stopped on a breakpoint.
- `insn_count`  out  CNT_W — number of fetches performed while enabled.

## Operation
- **Button path.**
  - 2-flop synchronizer: `button` → `s1` → `s2`.
  - Debounce counter `dcnt`:
    - clears to 0 on any cycle where `s2 == db`;
    - otherwise increments;
    - on the edge where `dcnt == DEBOUNCE_LEN-1` and `s2 != db`, it loads `db <= s2` and `dcnt <= 0`.
  - `btn_pulse = db & ~db_q`: exactly one cycle per debounced press. Releases produce no pulse.
- **FSM states.** HALT, STEP, RUN. A `moved` flag is set on any cycle with `core_en=1` and cleared on every transition into STEP or RUN. Breakpoints are armed continuously while `mode == 11`.
- **Stop conditions** (let `stop_bp = fetch & moved & (pc == bp_addr) & (mode == 11)`):
  - STEP stops when `fetch & moved`.
  - RUN stops when `stop_bp`.
  - The core halts before latching the instruction, so a step executes exactly one instruction from any halt point. Starting mid-instruction, a step finishes the current instruction.
- **`core_en` (combinational).**
  - HALT: 0.
  - STEP: `~(fetch & moved)`.
  - RUN: `~stop_bp`.
- **Transitions.**
  - HALT + `btn_pulse`:
    - `mode=01` → STEP;
    - `mode=10` or `11` → RUN, and `bp_hit <= 0`;
    - `mode=00` → no change.
  - STEP: when `fetch & moved` → HALT. `btn_pulse` is ignored.
  - RUN:
    - `stop_bp` → HALT with `bp_hit <= 1`;
    - otherwise `btn_pulse` → HALT (immediate; this may stop mid-instruction).
  - A mode change outside HALT has no effect except arming/disarming the breakpoint.
- **Counter.** `insn_count` increments on every cycle with `core_en & fetch` and wraps modulo 2^CNT_W.
- **Resume from breakpoint.** Resuming from a breakpoint at `bp_addr` proceeds, because `moved` is 0 on the first RUN cycle.
- **Reset.** On `res`:
  - state HALT;
  - `halted=1`, `core_en=0`, `bp_hit=0`, `insn_count=0`;
  - `moved=0`, `s1=s2=db=db_q=0`, `dcnt=0`.
  - Reset mid-RUN or mid-STEP drops `core_en` in the cycle `res` is sampled high. The core's own reset is asserted alongside.

## Timing
- All registers update on the rising `clk` edge.
- **Press latency.** With `button` held high and first sampled at edge E1:
  - `s2=1` after E2;
  - `db=1` after edge E(DEBOUNCE_LEN+2);
  - `btn_pulse` high for the following cycle;
  - state changes at edge E(DEBOUNCE_LEN+3);
  - the first `core_en=1` cycle immediately follows.
- A bounce (`s2` returning to `db`) restarts the count.
- **Stop boundary.** `core_en` falls combinationally in the same cycle the stop condition holds. The state is HALT after that edge, so no enabled fetch cycle slips through.
- **Status outputs.** `halted` and `bp_hit` are registered: valid the cycle after the transition edge.
- **Counter.** `insn_count` is registered, +1 visible the cycle after the enabled fetch.

## Test plan
Benches use `DEBOUNCE_LEN=4`.
- **Reset.** Assert `res` 2 cycles → `halted=1`, `core_en=0`, `bp_hit=0`, `insn_count=0`. Pulse `button` for 3 cycles only → no state change.
- **Step.**
  - Stimulus: `mode=01`, core model with 4-microcycle instructions and `fetch` on microcycle 0; hold `button` high.
  - Response: `core_en` rises at the cycle after edge E7; exactly 4 enabled cycles; halts with `pc` advanced by 1; `insn_count=1`.
- **Run.** `mode=10`, press → `core_en` continuously high. Second press → `core_en` 0 from the cycle after that press's `btn_pulse`, `halted=1`.
- **Breakpoint.**
  - Run: `mode=11`, `bp_addr=8'h05`, start at `pc=0` → halt with `core_en=0` while `fetch=1`, `pc=05`; `bp_hit=1`; `insn_count=5`.
  - Resume: press again → resumes past `05` (`moved` gating), `bp_hit` cleared.
- **Counter wrap.** `CNT_W=4`, run 17 instructions → `insn_count=1`.
- **Reset mid-RUN.** Assert `res` while in RUN → `core_en=0` in the same cycle, all outputs at reset values after the edge.
